// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package    : alu_pkg                                               |
// | Description: Opcode encodings, port identifiers and the opcode     |
// |              legality check shared by the ALU arbiter files.       |
// | Revision   : 1.0  initial release                                  |
// +--------------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // True for the six opcodes the ALU implements; anything else is
  // still issued but reported back as an error.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: legal = 1'b1;
      default:                                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_resp_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : alu_resp_reg                                          |
// | Description: Per-port response holding register. Captures an ALU  |
// |              result and holds it until the port accepts it.        |
// | Revision   : 1.0  initial release                                  |
// +--------------------------------------------------------------------+
module alu_resp_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              cap_zero,
  input  logic              cap_err,
  input  logic              resp_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_zero,
  output logic              resp_err
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_zero;
  logic              r_err;

  // Capture has priority over drain so a result arriving while the old
  // one is being accepted replaces it and keeps valid asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_zero  <= 1'b0;
      r_err   <= 1'b0;
    end else if (capture) begin
      r_valid <= 1'b1;
      r_data  <= cap_data;
      r_zero  <= cap_zero;
      r_err   <= cap_err;
    end else if (r_valid && resp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign resp_valid = r_valid;
  assign resp_data  = r_data;
  assign resp_zero  = r_zero;
  assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : alu_arbiter                                           |
// | Description: Round-robin sharing of one registered ALU between two |
// |              requesters, with per-port response registers and an   |
// |              issued-operation counter.                             |
// | Revision   : 1.0  initial release                                  |
// +--------------------------------------------------------------------+
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // port A
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic [OP_W-1:0]   a_req_op,
  input  logic [DATA_W-1:0] a_req_opnd1,
  input  logic [DATA_W-1:0] a_req_opnd2,
  output logic              a_resp_valid,
  input  logic              a_resp_ready,
  output logic [DATA_W-1:0] a_resp_data,
  output logic              a_resp_zero,
  output logic              a_resp_err,
  // port B
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic [OP_W-1:0]   b_req_op,
  input  logic [DATA_W-1:0] b_req_opnd1,
  input  logic [DATA_W-1:0] b_req_opnd2,
  output logic              b_resp_valid,
  input  logic              b_resp_ready,
  output logic [DATA_W-1:0] b_resp_data,
  output logic              b_resp_zero,
  output logic              b_resp_err,
  // ALU interface
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_opnd1,
  output logic [DATA_W-1:0] alu_opnd2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic [CNT_W-1:0]  issued_cnt
);

  logic             r_inflight;
  logic             r_owner;
  logic             r_rr_last;
  logic             r_err_pend;
  logic [CNT_W-1:0] r_issued_cnt;

  logic w_inflight_a, w_inflight_b;
  logic w_elig_a, w_elig_b;
  logic w_gnt_a, w_gnt_b, w_gnt_any;

  assign w_inflight_a = r_inflight && (r_owner == PORT_A);
  assign w_inflight_b = r_inflight && (r_owner == PORT_B);

  // A port may not issue while its own op is in flight or while its
  // response register holds data that will not be drained this cycle.
  assign w_elig_a = a_req_valid && !w_inflight_a && (!a_resp_valid || a_resp_ready);
  assign w_elig_b = b_req_valid && !w_inflight_b && (!b_resp_valid || b_resp_ready);

  assign w_gnt_a   = w_elig_a && (!w_elig_b || (r_rr_last == PORT_B));
  assign w_gnt_b   = w_elig_b && !w_gnt_a;
  assign w_gnt_any = w_gnt_a || w_gnt_b;

  assign a_req_ready = w_gnt_a;
  assign b_req_ready = w_gnt_b;

  // Drive the ALU from the granted port; idle cycles present an AND of zeros.
  always_comb begin
    alu_op    = '0;
    alu_opnd1 = '0;
    alu_opnd2 = '0;
    if (w_gnt_a) begin
      alu_op    = a_req_op;
      alu_opnd1 = a_req_opnd1;
      alu_opnd2 = a_req_opnd2;
    end else if (w_gnt_b) begin
      alu_op    = b_req_op;
      alu_opnd1 = b_req_opnd1;
      alu_opnd2 = b_req_opnd2;
    end
  end

  // Issue bookkeeping: owner, fairness pointer, error flag and op count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight   <= 1'b0;
      r_owner      <= PORT_A;
      r_rr_last    <= PORT_B;
      r_err_pend   <= 1'b0;
      r_issued_cnt <= '0;
    end else if (w_gnt_any) begin
      r_inflight   <= 1'b1;
      r_owner      <= w_gnt_b ? PORT_B : PORT_A;
      r_rr_last    <= w_gnt_b ? PORT_B : PORT_A;
      r_err_pend   <= !is_legal_op(alu_op);
      r_issued_cnt <= r_issued_cnt + 1'b1;
    end else begin
      r_inflight   <= 1'b0;
    end
  end

  assign issued_cnt = r_issued_cnt;

  alu_resp_reg #(.DATA_W(DATA_W)) u_resp_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (w_inflight_a),
    .cap_data   (alu_out),
    .cap_zero   (alu_zero),
    .cap_err    (r_err_pend),
    .resp_ready (a_resp_ready),
    .resp_valid (a_resp_valid),
    .resp_data  (a_resp_data),
    .resp_zero  (a_resp_zero),
    .resp_err   (a_resp_err)
  );

  alu_resp_reg #(.DATA_W(DATA_W)) u_resp_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .capture    (w_inflight_b),
    .cap_data   (alu_out),
    .cap_zero   (alu_zero),
    .cap_err    (r_err_pend),
    .resp_ready (b_resp_ready),
    .resp_valid (b_resp_valid),
    .resp_data  (b_resp_data),
    .resp_zero  (b_resp_zero),
    .resp_err   (b_resp_err)
  );

endmodule
`default_nettype wire
